// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first rep_cnt times,
// with gap idle-zero bits between repetitions and a done pulse at the end.
module seq_pattern_tx #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             dout,
  output logic             dvalid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   reps_left_q, reps_left_d;
  logic [GAP_W-1:0]   gap_len_q, gap_len_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      reps_left_q <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      reps_left_q <= reps_left_d;
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    reps_left_d = reps_left_q;
    gap_len_d   = gap_len_q;
    gap_cnt_d   = gap_cnt_q;

    case (state_q)
      IDLE: begin
        if (start && (rep_cnt != '0)) begin
          reps_left_d = rep_cnt;
          gap_len_d   = gap;
          bit_idx_d   = LAST_IDX;
          state_d     = SEND;
        end
      end

      SEND: begin
        if (abort) begin
          state_d     = IDLE;
          bit_idx_d   = '0;
          reps_left_d = '0;
          gap_len_d   = '0;
          gap_cnt_d   = '0;
        end else if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_q - 1'b1;
        end else if (reps_left_q == CNT_W'(1)) begin
          reps_left_d = '0;
          state_d     = DONE;
        end else begin
          reps_left_d = reps_left_q - 1'b1;
          // Zero gap chains repetitions back-to-back without leaving SEND
          if (gap_len_q == '0) begin
            bit_idx_d = LAST_IDX;
          end else begin
            gap_cnt_d = gap_len_q;
            state_d   = GAP;
          end
        end
      end

      GAP: begin
        if (abort) begin
          state_d     = IDLE;
          bit_idx_d   = '0;
          reps_left_d = '0;
          gap_len_d   = '0;
          gap_cnt_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
          if (gap_cnt_q == GAP_W'(1)) begin
            bit_idx_d = LAST_IDX;
            state_d   = SEND;
          end
        end
      end

      DONE: begin
        state_d     = IDLE;
        bit_idx_d   = '0;
        reps_left_d = '0;
        gap_len_d   = '0;
        gap_cnt_d   = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only, so reset forces them low at once
  assign dout        = (state_q == SEND) && PATTERN[bit_idx_q];
  assign dvalid      = (state_q == SEND);
  assign frame_start = (state_q == SEND) && (bit_idx_q == LAST_IDX);
  assign busy        = (state_q == SEND) || (state_q == GAP);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: per-cycle output traces are compared
// against hand-written bit strings, plus a loopback 1010 detector count.
module tb_seq_pattern_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] rep_cnt;
  logic [3:0] gap;
  logic       abort;
  logic       dout;
  logic       dvalid;
  logic       frame_start;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  logic [31:0] cap_dout;
  logic [31:0] cap_dvalid;
  logic [31:0] cap_frame;
  logic [31:0] cap_busy;
  logic [31:0] cap_done;
  logic [2:0]  det_sr;
  int          det_count;

  seq_pattern_tx dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rep_cnt     (rep_cnt),
    .gap         (gap),
    .abort       (abort),
    .dout        (dout),
    .dvalid      (dvalid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Request a transfer; the start edge is the one just before cycle 1
  task automatic applyStimulus(input logic [7:0] reps, input logic [3:0] gap_in);
    @(negedge clk);
    start   = 1'b1;
    rep_cnt = reps;
    gap     = gap_in;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Record n cycles of outputs (cycle 1 lands in bit n-1); optionally inject
  // a stray start or an abort during the given cycle
  task automatic captureCycles(input int n, input int pulse_at, input int abort_at);
    cap_dout   = '0;
    cap_dvalid = '0;
    cap_frame  = '0;
    cap_busy   = '0;
    cap_done   = '0;
    det_sr     = '0;
    det_count  = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      cap_dout   = {cap_dout[30:0], dout};
      cap_dvalid = {cap_dvalid[30:0], dvalid};
      cap_frame  = {cap_frame[30:0], frame_start};
      cap_busy   = {cap_busy[30:0], busy};
      cap_done   = {cap_done[30:0], done};
      if ({det_sr, dout} == 4'b1010) begin
        det_count++;
        det_sr = '0;
      end else begin
        det_sr = {det_sr[1:0], dout};
      end
      start = 1'b0;
      abort = 1'b0;
      if (i == pulse_at) begin
        start   = 1'b1;
        rep_cnt = 8'd5;
        gap     = 4'd3;
      end
      if (i == abort_at) abort = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic checkTrace(input string tag, input logic [31:0] e_dout,
                            input logic [31:0] e_dvalid, input logic [31:0] e_frame,
                            input logic [31:0] e_busy, input logic [31:0] e_done,
                            input int e_det);
    checkOutput({tag, "_dout"},   cap_dout,   e_dout);
    checkOutput({tag, "_dvalid"}, cap_dvalid, e_dvalid);
    checkOutput({tag, "_frame"},  cap_frame,  e_frame);
    checkOutput({tag, "_busy"},   cap_busy,   e_busy);
    checkOutput({tag, "_done"},   cap_done,   e_done);
    checkOutput({tag, "_det"},    32'(det_count), 32'(e_det));
  endtask

  task automatic runSingle(input string tag);
    applyStimulus(8'd1, 4'd0);
    captureCycles(6, 0, 0);
    checkTrace(tag, 32'b101000, 32'b111100, 32'b100000, 32'b111100, 32'b000010, 1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    rep_cnt = '0;
    gap     = '0;
    abort   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", 32'({dout, dvalid, frame_start, busy, done}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_outputs", 32'({dout, dvalid, frame_start, busy, done}), 32'd0);

    // Single repetition
    runSingle("t1");

    // Three repetitions separated by two idle bits
    applyStimulus(8'd3, 4'd2);
    captureCycles(18, 0, 0);
    checkTrace("t2", 32'b101000101000101000, 32'b111100111100111100,
               32'b100000100000100000, 32'b111111111111111100,
               32'b000000000000000010, 3);

    // Back-to-back repetitions
    applyStimulus(8'd2, 4'd0);
    captureCycles(10, 0, 0);
    checkTrace("t3", 32'b1010101000, 32'b1111111100, 32'b1000100000,
               32'b1111111100, 32'b0000000010, 2);

    // Single idle bit between repetitions
    applyStimulus(8'd2, 4'd1);
    captureCycles(11, 0, 0);
    checkTrace("t3b", 32'b10100101000, 32'b11110111100, 32'b10000100000,
               32'b11111111100, 32'b00000000010, 2);

    // rep_cnt of zero is ignored
    applyStimulus(8'd0, 4'd2);
    captureCycles(10, 0, 0);
    checkTrace("t4a", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);

    // Stray start during a transfer neither restarts nor extends it
    applyStimulus(8'd2, 4'd0);
    captureCycles(12, 3, 0);
    checkTrace("t4b", 32'b101010100000, 32'b111111110000, 32'b100010000000,
               32'b111111110000, 32'b000000001000, 2);

    // Abort during the second gap cycle
    applyStimulus(8'd3, 4'd3);
    captureCycles(10, 0, 6);
    checkTrace("t5", 32'b1010000000, 32'b1111000000, 32'b1000000000,
               32'b1111110000, 32'b0000000000, 1);

    // Asynchronous reset on the third bit of the second repetition
    applyStimulus(8'd3, 4'd0);
    repeat (7) @(negedge clk);
    checkOutput("t6_pre_reset", 32'({dout, dvalid, frame_start, busy, done}), 32'b11010);
    reset = 1'b1;
    #1;
    checkOutput("t6_async_reset", 32'({dout, dvalid, frame_start, busy, done}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    captureCycles(4, 0, 0);
    checkOutput("t6_stays_idle", cap_busy | cap_done | cap_dvalid, 32'd0);
    runSingle("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
